// File: rtl/bp_fe_lce_cmd_fill.sv
// ---------------------------------------------------------------------------
// bp_fe_lce_cmd_fill
//
// Instruction-cache LCE command side. Accepts CCE->LCE commands one at a time,
// turns them into tag-memory / data-memory write requests, returns an
// invalidate acknowledgement to the CCE, captures uncached data and raises
// the single-cycle completion pulses consumed by the LCE request FSM.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   lce_cmd_*                      incoming command (valid / consume handshake)
//   tag_mem_*                      tag write request (set valid or invalidate)
//   data_mem_*                     data block write request
//   lce_resp_*                     invalidate acknowledgement to the CCE
//   uncached_data_o                low 64 bits of the last uncached data command
//   *_received_o                   one-cycle completion pulses
//   coherence_blocked_o            a memory write is pending but not accepted
//   fill_count_o                   completed data fills
//
// Configuration
//   BP_FE_LCE_CMD_FILL_STATS_EN    when defined, fill_count_o counts completed
//                                  data fills (saturating); otherwise it is 0.
// ---------------------------------------------------------------------------
module bp_fe_lce_cmd_fill #(
    parameter int paddr_width_p = 40,
    parameter int ptag_width_p  = 28,
    parameter int sets_p        = 64,
    parameter int assoc_p       = 8,
    parameter int block_width_p = 512,
    localparam int index_w_lp   = $clog2(sets_p),
    localparam int way_w_lp     = $clog2(assoc_p),
    localparam int boff_w_lp    = $clog2(block_width_p / 8)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     lce_cmd_v_i,
    output logic                     lce_cmd_yumi_o,
    input  logic [2:0]               lce_cmd_type_i,
    input  logic [paddr_width_p-1:0] lce_cmd_addr_i,
    input  logic [way_w_lp-1:0]      lce_cmd_way_i,
    input  logic [block_width_p-1:0] lce_cmd_data_i,

    output logic                     tag_mem_v_o,
    input  logic                     tag_mem_yumi_i,
    output logic                     tag_mem_inv_o,
    output logic [index_w_lp-1:0]    tag_mem_index_o,
    output logic [way_w_lp-1:0]      tag_mem_way_o,
    output logic [ptag_width_p-1:0]  tag_mem_tag_o,

    output logic                     data_mem_v_o,
    input  logic                     data_mem_yumi_i,
    output logic [index_w_lp-1:0]    data_mem_index_o,
    output logic [way_w_lp-1:0]      data_mem_way_o,
    output logic [block_width_p-1:0] data_mem_data_o,

    output logic                     lce_resp_v_o,
    input  logic                     lce_resp_yumi_i,
    output logic [paddr_width_p-1:0] lce_resp_addr_o,

    output logic [63:0]              uncached_data_o,
    output logic                     cce_data_received_o,
    output logic                     set_tag_received_o,
    output logic                     set_tag_wakeup_received_o,
    output logic                     uncached_data_received_o,
    output logic                     coherence_blocked_o,
    output logic [31:0]              fill_count_o
);

    // Command encodings on lce_cmd_type_i
    localparam logic [2:0] CMD_SET_TAG        = 3'd0;
    localparam logic [2:0] CMD_SET_TAG_WAKEUP = 3'd1;
    localparam logic [2:0] CMD_INVALIDATE     = 3'd2;
    localparam logic [2:0] CMD_DATA           = 3'd3;
    localparam logic [2:0] CMD_UC_DATA        = 3'd4;

    typedef enum logic [2:0] {
        ST_READY   = 3'd0,
        ST_TAG_WR  = 3'd1,
        ST_INV_WR  = 3'd2,
        ST_INV_ACK = 3'd3,
        ST_DATA_WR = 3'd4,
        ST_UC      = 3'd5
    } state_e;

    // Set index taken from the bits just above the block offset
    function automatic logic [index_w_lp-1:0] addr_index_f(input logic [paddr_width_p-1:0] addr);
        return addr[boff_w_lp +: index_w_lp];
    endfunction

    // Physical tag is the top ptag_width_p address bits
    function automatic logic [ptag_width_p-1:0] addr_tag_f(input logic [paddr_width_p-1:0] addr);
        return addr[paddr_width_p-1 -: ptag_width_p];
    endfunction

    // State entered after consuming a command; unknown types are dropped
    function automatic state_e next_state_f(input logic [2:0] cmd_type);
        state_e nxt;
        case (cmd_type)
            CMD_SET_TAG,
            CMD_SET_TAG_WAKEUP: nxt = ST_TAG_WR;
            CMD_INVALIDATE:     nxt = ST_INV_WR;
            CMD_DATA:           nxt = ST_DATA_WR;
            CMD_UC_DATA:        nxt = ST_UC;
            default:            nxt = ST_READY;
        endcase
        return nxt;
    endfunction

    state_e                     state_r;
    logic [2:0]                 type_r;
    logic [paddr_width_p-1:0]   addr_r;
    logic [way_w_lp-1:0]        way_r;
    logic [block_width_p-1:0]   data_r;
    logic [63:0]                uc_data_r;
    logic                       tag_v_r;
    logic                       tag_inv_r;
    logic                       data_v_r;
    logic                       resp_v_r;

    logic                       cmd_yumi_s;
    logic                       tag_done_s;
    logic                       data_done_s;

    // A command is only taken while idle; gated by reset so nothing is
    // consumed while the block is held in reset.
    assign cmd_yumi_s  = lce_cmd_v_i & (state_r == ST_READY) & ~reset_i;
    assign tag_done_s  = tag_v_r & tag_mem_yumi_i & (state_r == ST_TAG_WR);
    assign data_done_s = data_v_r & data_mem_yumi_i & (state_r == ST_DATA_WR);

    // Command FSM: captures the command and owns every request valid flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= ST_READY;
            type_r    <= 3'd0;
            addr_r    <= {paddr_width_p{1'b0}};
            way_r     <= {way_w_lp{1'b0}};
            data_r    <= {block_width_p{1'b0}};
            uc_data_r <= 64'd0;
            tag_v_r   <= 1'b0;
            tag_inv_r <= 1'b0;
            data_v_r  <= 1'b0;
            resp_v_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_READY: begin
                    if (cmd_yumi_s) begin
                        type_r    <= lce_cmd_type_i;
                        addr_r    <= lce_cmd_addr_i;
                        way_r     <= lce_cmd_way_i;
                        data_r    <= lce_cmd_data_i;
                        state_r   <= next_state_f(lce_cmd_type_i);
                        tag_v_r   <= (lce_cmd_type_i == CMD_SET_TAG)
                                   | (lce_cmd_type_i == CMD_SET_TAG_WAKEUP)
                                   | (lce_cmd_type_i == CMD_INVALIDATE);
                        tag_inv_r <= (lce_cmd_type_i == CMD_INVALIDATE);
                        data_v_r  <= (lce_cmd_type_i == CMD_DATA);
                    end
                end
                ST_TAG_WR: begin
                    if (tag_mem_yumi_i) begin
                        tag_v_r <= 1'b0;
                        state_r <= ST_READY;
                    end
                end
                ST_INV_WR: begin
                    // Ack goes out only after the invalidate has landed
                    if (tag_mem_yumi_i) begin
                        tag_v_r   <= 1'b0;
                        tag_inv_r <= 1'b0;
                        resp_v_r  <= 1'b1;
                        state_r   <= ST_INV_ACK;
                    end
                end
                ST_INV_ACK: begin
                    if (lce_resp_yumi_i) begin
                        resp_v_r <= 1'b0;
                        state_r  <= ST_READY;
                    end
                end
                ST_DATA_WR: begin
                    if (data_mem_yumi_i) begin
                        data_v_r <= 1'b0;
                        state_r  <= ST_READY;
                    end
                end
                ST_UC: begin
                    uc_data_r <= data_r[63:0];
                    state_r   <= ST_READY;
                end
                default: begin
                    tag_v_r   <= 1'b0;
                    tag_inv_r <= 1'b0;
                    data_v_r  <= 1'b0;
                    resp_v_r  <= 1'b0;
                    state_r   <= ST_READY;
                end
            endcase
        end
    end

    assign lce_cmd_yumi_o   = cmd_yumi_s;

    // Request fields come straight from the captured command, so they stay
    // stable for as long as the matching valid is held.
    assign tag_mem_v_o      = tag_v_r;
    assign tag_mem_inv_o    = tag_inv_r;
    assign tag_mem_index_o  = addr_index_f(addr_r);
    assign tag_mem_way_o    = way_r;
    assign tag_mem_tag_o    = tag_inv_r ? {ptag_width_p{1'b0}} : addr_tag_f(addr_r);

    assign data_mem_v_o     = data_v_r;
    assign data_mem_index_o = addr_index_f(addr_r);
    assign data_mem_way_o   = way_r;
    assign data_mem_data_o  = data_r;

    assign lce_resp_v_o     = resp_v_r;
    assign lce_resp_addr_o  = addr_r;

    assign uncached_data_o  = uc_data_r;

    // Completion pulses fire in the cycle the memory accepts the write
    assign set_tag_received_o        = tag_done_s & (type_r == CMD_SET_TAG);
    assign set_tag_wakeup_received_o = tag_done_s & (type_r == CMD_SET_TAG_WAKEUP);
    assign cce_data_received_o       = data_done_s;
    assign uncached_data_received_o  = (state_r == ST_UC);

    assign coherence_blocked_o = (tag_v_r & ~tag_mem_yumi_i) | (data_v_r & ~data_mem_yumi_i);

`ifdef BP_FE_LCE_CMD_FILL_STATS_EN
    logic [31:0] fill_count_r;

    // Saturating count of completed data fills
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fill_count_r <= 32'd0;
        end else if (data_done_s && (fill_count_r != 32'hFFFF_FFFF)) begin
            fill_count_r <= fill_count_r + 32'd1;
        end
    end

    assign fill_count_o = fill_count_r;
`else
    assign fill_count_o = 32'd0;
`endif

endmodule
